hazard_tracker: RTL and testbench
=================================

HAZARD_TRACKER -- requirements
Module: hazard_tracker

Interface
REQ-001 The block SHALL use these ports, listed as name, direction, width, meaning:
- clk, input, 1, single clock, rising edge.
- reset, input, 1, asynchronous active-low reset.
- D_rs, input, 5, rs index of the instruction in D.
- D_rt, input, 5, rt index of the instruction in D.
- D_Tuse_rs, input, 2, cycles until D needs rs; 3 = unused.
- D_Tuse_rt, input, 2, same for rt.
- D_A3, input, 5, destination register of the D instruction.
- D_Tnew, input, 2, Tnew at E entry; 3 = no write.
- D_md_start, input, 1, D instruction is mult/multu/div/divu.
- D_md_div, input, 1, with D_md_start: 1 = div class, 0 = mult class.
- D_md_use, input, 1, D instruction touches the HI/LO unit (mult/div/mfhi/mflo/mthi/mtlo).
- stall, output, 1, freeze PC and D; bubble into E.
- fwd_rs_sel, output, 2, 0 = GRF, 1 = E, 2 = M, 3 = W.
- fwd_rt_sel, output, 2, same encoding as fwd_rs_sel.
- md_busy, output, 1, mult/div unit occupied.

REQ-002 Clock is named clk and reset is named reset; reset is asynchronous and active-low (0 = reset asserted), with one clock domain.

Function
REQ-003 The block SHALL hold three slot registers, E, M and W, each {A3[4:0], Tnew[1:0]}, plus an E_md_start flag, an E_md_div flag, and a 4-bit md counter.
REQ-004 On each rising edge when stall=0, slot E SHALL load {D_A3, D_Tnew}, and E_md_start and E_md_div SHALL load D_md_start and D_md_div.
REQ-005 On each rising edge when stall=1, slot E SHALL load the bubble {0, 3} and E_md_start SHALL load 0.
REQ-006 Every edge, M SHALL load E with Tnew aged, and W SHALL load M with Tnew aged. Aging is 2->1, 1->0, 0->0, 3->3.
REQ-007 A slot "matches" register r when r!=0, slot A3==r, and slot Tnew!=3.
REQ-008 For each of rs and rt, only the youngest matching slot (priority E > M > W) SHALL be considered.
REQ-009 A hazard exists when the youngest match has Tnew > Tuse. Tuse=3 never hazards.
REQ-010 stall SHALL be combinational: (rs hazard) | (rt hazard) | (D_md_use & md_busy).
REQ-011 fwd_x_sel SHALL select the stage of the youngest match when its Tnew==0, and 0 otherwise, including when there is no match and when register 0 is referenced.
REQ-012 The forwarding selects SHALL be valid regardless of stall; downstream ignores them while stalled.
REQ-013 The md counter SHALL load 5 when E_md_start=1 and E_md_div=0, and load 10 when E_md_start=1 and E_md_div=1.
REQ-014 Otherwise the md counter SHALL decrement while nonzero and hold at 0.
REQ-015 md_busy SHALL equal E_md_start | (counter != 0).
REQ-016 A D_md_start instruction arriving while md_busy=1 SHALL stall, because D_md_use is also set for it.
REQ-017 The block SHALL add no latency: stall and the selects are combinational in the current D inputs and the slot state.

Reset
REQ-018 While reset=0, the E, M and W slots SHALL be {0, 3}, and E_md_start, E_md_div and the counter SHALL be 0, independent of clk.
REQ-019 Immediately after reset, with no D hazards present: stall=0, fwd_rs_sel=0, fwd_rt_sel=0, md_busy=0.
REQ-020 Reset asserted mid-division SHALL clear md_busy within the same cycle, with no clock edge required.

Verification
REQ-021 lw to $8 issued, then D has rs=8 with Tuse_rs=0 -> stall=1 for 2 cycles, then fwd_rs_sel=3 with stall=0.
REQ-022 addu to $9 issued, then D has rt=9 with Tuse_rt=1 -> stall=0 and fwd_rt_sel=1 in the next cycle; one cycle later fwd_rt_sel=2.
REQ-023 addu to $5 in M and ori to $5 in E, then D reads rs=5 -> E takes priority: fwd_rs_sel=1, not 2.
REQ-024 D_A3=0 with Tnew=1, then D reads rs=0 with Tuse=0 -> stall=0 and fwd_rs_sel=0.
REQ-025 div issued, then mflo in D -> md_busy=1 and stall=1 for 11 cycles (1 cycle in E plus 10 counter cycles); a mult under the same conditions gives 6 cycles.
REQ-026 Reset pulsed low for a partial cycle while the counter=7 -> md_busy=0 immediately, and all selects read 0.

Source files
------------

// File: rtl/hazard_tracker.sv
// Pipeline hazard tracker: tracks in-flight destination registers in E/M/W,
// resolves stall and forwarding selects for the D instruction, and models mult/div occupancy.
module hazard_tracker (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] D_rs,
    input  logic [4:0] D_rt,
    input  logic [1:0] D_Tuse_rs,
    input  logic [1:0] D_Tuse_rt,
    input  logic [4:0] D_A3,
    input  logic [1:0] D_Tnew,
    input  logic       D_md_start,
    input  logic       D_md_div,
    input  logic       D_md_use,
    output logic       stall,
    output logic [1:0] fwd_rs_sel,
    output logic [1:0] fwd_rt_sel,
    output logic       md_busy
);

    localparam int unsigned REG_W = 5;
    localparam int unsigned T_W   = 2;
    localparam int unsigned CNT_W = 4;

    localparam logic [T_W-1:0]   T_NONE      = T_W'(3);
    localparam logic [CNT_W-1:0] MD_MULT_CYC = CNT_W'(5);
    localparam logic [CNT_W-1:0] MD_DIV_CYC  = CNT_W'(10);

    logic [REG_W-1:0] e_a3, m_a3, w_a3;
    logic [T_W-1:0]   e_tnew, m_tnew, w_tnew;
    logic             e_md_start, e_md_div;
    logic [CNT_W-1:0] md_cnt;

    logic [1:0]       rs_stage, rt_stage;
    logic [T_W-1:0]   rs_tnew, rt_tnew;
    logic             rs_hazard, rt_hazard;

    // One stage of progress: the write gets one cycle closer, 0 and "no write" stay put.
    function automatic logic [T_W-1:0] age(input logic [T_W-1:0] t);
        return (t == T_W'(0) || t == T_NONE) ? t : t - T_W'(1);
    endfunction

    // Youngest in-flight writer of r as {stage, tnew}; stage 0 means none.
    function automatic logic [3:0] youngest(
        input logic [REG_W-1:0] r,
        input logic [REG_W-1:0] ea, input logic [T_W-1:0] et,
        input logic [REG_W-1:0] ma, input logic [T_W-1:0] mt,
        input logic [REG_W-1:0] wa, input logic [T_W-1:0] wt
    );
        logic [3:0] res;
        res = {2'd0, T_NONE};
        if (r != REG_W'(0)) begin
            if (ea == r && et != T_NONE)      res = {2'd1, et};
            else if (ma == r && mt != T_NONE) res = {2'd2, mt};
            else if (wa == r && wt != T_NONE) res = {2'd3, wt};
        end
        return res;
    endfunction

    always_comb begin
        {rs_stage, rs_tnew} = youngest(D_rs, e_a3, e_tnew, m_a3, m_tnew, w_a3, w_tnew);
        {rt_stage, rt_tnew} = youngest(D_rt, e_a3, e_tnew, m_a3, m_tnew, w_a3, w_tnew);
    end

    always_comb begin
        rs_hazard  = (rs_stage != 2'd0) && (rs_tnew > D_Tuse_rs);
        rt_hazard  = (rt_stage != 2'd0) && (rt_tnew > D_Tuse_rt);
        md_busy    = e_md_start || (md_cnt != CNT_W'(0));
        stall      = rs_hazard || rt_hazard || (D_md_use && md_busy);
        fwd_rs_sel = (rs_stage != 2'd0 && rs_tnew == T_W'(0)) ? rs_stage : 2'd0;
        fwd_rt_sel = (rt_stage != 2'd0 && rt_tnew == T_W'(0)) ? rt_stage : 2'd0;
    end

    // Slot pipeline; a stall injects a bubble into E while M and W keep draining.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_a3       <= '0;
            e_tnew     <= T_NONE;
            m_a3       <= '0;
            m_tnew     <= T_NONE;
            w_a3       <= '0;
            w_tnew     <= T_NONE;
            e_md_start <= 1'b0;
            e_md_div   <= 1'b0;
        end else begin
            if (stall) begin
                e_a3       <= '0;
                e_tnew     <= T_NONE;
                e_md_start <= 1'b0;
                e_md_div   <= 1'b0;
            end else begin
                e_a3       <= D_A3;
                e_tnew     <= D_Tnew;
                e_md_start <= D_md_start;
                e_md_div   <= D_md_div;
            end
            m_a3   <= e_a3;
            m_tnew <= age(e_tnew);
            w_a3   <= m_a3;
            w_tnew <= age(m_tnew);
        end
    end

    // Mult/div occupancy counter, armed as the operation leaves E.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_cnt <= '0;
        end else if (e_md_start) begin
            md_cnt <= e_md_div ? MD_DIV_CYC : MD_MULT_CYC;
        end else if (md_cnt != CNT_W'(0)) begin
            md_cnt <= md_cnt - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_tracker.sv
// Bench for hazard_tracker: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against an instruction-history model.
`timescale 1ns/1ps
module tb_hazard_tracker;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] D_rs, D_rt, D_A3;
    logic [1:0] D_Tuse_rs, D_Tuse_rt, D_Tnew;
    logic       D_md_start, D_md_div, D_md_use;
    logic       stall, md_busy;
    logic [1:0] fwd_rs_sel, fwd_rt_sel;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: the last three instructions issued into E (index 0 = E) with their Tnew at E entry.
    int h_a3[3];
    int h_t[3];
    bit e_md, e_div;
    int cyc;
    int md_last;

    hazard_tracker dut (
        .clk(clk), .reset(reset),
        .D_rs(D_rs), .D_rt(D_rt), .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt),
        .D_A3(D_A3), .D_Tnew(D_Tnew),
        .D_md_start(D_md_start), .D_md_div(D_md_div), .D_md_use(D_md_use),
        .stall(stall), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel), .md_busy(md_busy)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            h_a3[k] = 0;
            h_t[k]  = 3;
        end
        e_md    = 0;
        e_div   = 0;
        md_last = -100;
    endtask

    function automatic int tnow(input int k);
        if (h_t[k] == 3) return 3;
        return (h_t[k] - k > 0) ? h_t[k] - k : 0;
    endfunction

    task automatic find(input int r, output int sel, output int tn);
        sel = 0;
        tn  = 3;
        if (r != 0) begin
            for (int k = 0; k < 3; k++) begin
                if (h_a3[k] == r && tnow(k) != 3) begin
                    sel = k + 1;
                    tn  = tnow(k);
                    break;
                end
            end
        end
    endtask

    task automatic model_eval(output int es, output int ers, output int ert, output int eb);
        int srs, trs, srt, trt;
        find(int'(D_rs), srs, trs);
        find(int'(D_rt), srt, trt);
        eb  = (e_md || cyc <= md_last) ? 1 : 0;
        es  = ((srs != 0 && trs > int'(D_Tuse_rs)) || (srt != 0 && trt > int'(D_Tuse_rt))
               || (D_md_use && eb == 1)) ? 1 : 0;
        ers = (srs != 0 && trs == 0) ? srs : 0;
        ert = (srt != 0 && trt == 0) ? srt : 0;
    endtask

    task automatic drive(input int rs, input int rt, input int trs, input int trt,
                         input int a3, input int tn, input int ms, input int md, input int mu);
        D_rs = 5'(rs); D_rt = 5'(rt); D_Tuse_rs = 2'(trs); D_Tuse_rt = 2'(trt);
        D_A3 = 5'(a3); D_Tnew = 2'(tn);
        D_md_start = 1'(ms); D_md_div = 1'(md); D_md_use = 1'(mu);
        #1;
    endtask

    task automatic nop();
        drive(0, 0, 3, 3, 0, 3, 0, 0, 0);
    endtask

    // Compare against the model for the current cycle, then advance one clock.
    task automatic step();
        int es, ers, ert, eb;
        #1;
        model_eval(es, ers, ert, eb);
        chk("stall", int'(stall), es);
        chk("fwd_rs_sel", int'(fwd_rs_sel), ers);
        chk("fwd_rt_sel", int'(fwd_rt_sel), ert);
        chk("md_busy", int'(md_busy), eb);
        @(posedge clk);
        for (int k = 2; k > 0; k--) begin
            h_a3[k] = h_a3[k-1];
            h_t[k]  = h_t[k-1];
        end
        if (es == 1) begin
            h_a3[0] = 0; h_t[0] = 3; e_md = 0; e_div = 0;
        end else begin
            h_a3[0] = int'(D_A3); h_t[0] = int'(D_Tnew);
            e_md = D_md_start; e_div = D_md_div;
        end
        cyc++;
        if (e_md) md_last = cyc + (e_div ? 10 : 5);
        #1;
    endtask

    task automatic lit(input string name, input int s, input int frs, input int frt, input int b);
        chk({name, ".stall"}, int'(stall), s);
        chk({name, ".fwd_rs"}, int'(fwd_rs_sel), frs);
        chk({name, ".fwd_rt"}, int'(fwd_rt_sel), frt);
        chk({name, ".md_busy"}, int'(md_busy), b);
    endtask

    task automatic flush();
        nop();
        for (int i = 0; i < 3; i++) step();
    endtask

    initial begin
        int n;
        cyc = 0;
        model_reset();
        reset = 1'b0;
        nop();
        #25;
        lit("reset_state", 0, 0, 0, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // load-use: two stall cycles then forward from W
        drive(0, 0, 3, 3, 8, 2, 0, 0, 0); step();
        drive(8, 0, 0, 3, 0, 3, 0, 0, 0);
        lit("lw_use_1", 1, 0, 0, 0); step();
        lit("lw_use_2", 1, 0, 0, 0); step();
        lit("lw_use_fwd", 0, 3, 0, 0); step();
        flush();

        // ALU result forwarded from E, then from M
        drive(0, 0, 3, 3, 9, 0, 0, 0, 0); step();
        drive(0, 9, 3, 1, 0, 3, 0, 0, 0);
        lit("alu_fwd_e", 0, 0, 1, 0); step();
        lit("alu_fwd_m", 0, 0, 2, 0); step();
        flush();

        // E has priority over M for the same register
        drive(0, 0, 3, 3, 5, 0, 0, 0, 0); step();
        drive(0, 0, 3, 3, 5, 0, 0, 0, 0); step();
        drive(5, 0, 0, 3, 0, 3, 0, 0, 0);
        lit("youngest_wins", 0, 1, 0, 0); step();
        flush();

        // writes to $0 never hazard or forward
        drive(0, 0, 3, 3, 0, 1, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 3, 0, 0, 0);
        lit("reg_zero", 0, 0, 0, 0); step();
        flush();

        // div then mflo: 11 stall cycles
        drive(0, 0, 3, 3, 0, 3, 1, 1, 1); step();
        drive(0, 0, 3, 3, 0, 3, 0, 0, 1);
        chk("div_busy", int'(md_busy), 1);
        n = 0;
        while (stall && n < 30) begin n++; step(); end
        chk("div_stall_cycles", n, 11);
        step();

        // mult then mflo: 6 stall cycles
        drive(0, 0, 3, 3, 0, 3, 1, 0, 1); step();
        drive(0, 0, 3, 3, 0, 3, 0, 0, 1);
        n = 0;
        while (stall && n < 30) begin n++; step(); end
        chk("mult_stall_cycles", n, 6);
        step();
        flush();

        // async reset mid-division with counter at 7
        drive(0, 0, 3, 3, 0, 3, 1, 1, 1); step();
        nop(); step(); step(); step();
        drive(0, 0, 3, 3, 6, 0, 0, 0, 0); step();
        drive(6, 0, 1, 3, 0, 3, 0, 0, 0);
        lit("pre_reset", 0, 1, 0, 1);
        reset = 1'b0;
        #1;
        lit("mid_reset", 0, 0, 0, 0);
        reset = 1'b1;
        model_reset();
        step();
        flush();

        // randomized traffic over a small register set to provoke collisions
        for (int i = 0; i < 400; i++) begin
            int ms, mu;
            ms = ($urandom_range(0, 15) == 0) ? 1 : 0;
            mu = (ms == 1 || $urandom_range(0, 7) == 0) ? 1 : 0;
            drive($urandom_range(0, 4), $urandom_range(0, 4),
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 4), $urandom_range(0, 3),
                  ms, $urandom_range(0, 1), mu);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
